jb_prach_cp_strip_wr: RTL and testbench
=======================================

# jb_prach_cp_strip_wr

Parametrised PRACH CP-removal and FFT-buffer write controller. It sits between the antenna-interleaved PRACH sample stream and the ping-pong FFT input RAM. After each sub-frame marker it skips a configurable timing offset and cyclic prefix, then writes 1 to 2^SYM_BW consecutive FFT windows per antenna into one bank. On completion it signals that bank ready and toggles to the other bank.

## Interface
- USR_ID_BW, 2: antenna-ID width carried on tuser
- NUM_ANT, 4: antennas interleaved per sample time, 1..2^USR_ID_BW
- PRECISION, 16: I/Q component width
- FFT_LOG2, 11: log2 of FFT window length in samples
- SYM_BW, 2: symbol-index width; up to 2^SYM_BW repeated windows
- clk  in  1  clock; one clock only
- reset  in  1  asynchronous, active-high
- clk_en  in  1  clock enable; all state holds when low
- sub_frame_mrkr  in  1  frame start strobe
- cfg_offset  in  16  samples to skip before CP
- cfg_cp_len  in  16  CP length in samples
- cfg_num_sym  in  SYM_BW+1  windows per frame, 1..2^SYM_BW; 0 is treated as 1
- IFP_in  jb_axi4_stream_if.slave  tdata 2*PRECISION, tuser USR_ID_BW; tready tied 1
- mem_wr_en  out  1  RAM write strobe
- mem_wr_addr  out  1+USR_ID_BW+SYM_BW+FFT_LOG2  {bank, ant, sym, idx}
- mem_wr_data  out  2*PRECISION  sample
- cp_mrkr  out  1  high for beats inside the CP region
- bank_done  out  1  one-cycle pulse when a bank is complete
- bank_done_id  out  1  bank that completed
- frame_err  out  1  pulse when a marker aborts a frame
- stat_frames, stat_errs  out  16 each  counters; see Configuration

## Operation
- Beat: clk_en && IFP_in.tvalid. Sample tick: a beat with tuser == NUM_ANT-1. Counters advance only on ticks.
- Config registers latch on the accepted marker (clk_en && sub_frame_mrkr).
- States:
  - IDLE: wait for a marker.
  - OFFSET: count cfg_offset ticks.
  - CP: count cfg_cp_len ticks.
  - DATA: idx counts 0..2^FFT_LOG2-1; sym increments on idx wrap.
- Transitions:
  - Marker: go to OFFSET. If cfg_offset=0, go to CP instead. If cfg_cp_len=0 as well, go to DATA.
  - Zero-length phases are skipped.
  - A beat arriving in the marker cycle counts as sample 0 of the new frame.
- DATA writes:
  - Every beat in DATA writes: addr = {bank, tuser, sym, idx}, data = tdata.
  - Beats with tuser ≥ NUM_ANT are dropped.
- Completion:
  - On the tick where idx wraps and sym = cfg_num_sym-1: bank_done pulses with bank_done_id = bank.
  - Bank then toggles and the state returns to IDLE.
- Marker outside IDLE: frame_err pulses, the frame restarts on the same bank (no toggle), and no bank_done is issued.
- cp_mrkr is high on beats while state == CP, aligned with the write pipeline.
- idx width is exactly FFT_LOG2 and wraps naturally. The sym compare uses SYM_BW+1 bits.

## Timing
- Write latency: 1 clk from input beat to mem_wr_* (registered outputs).
- bank_done is asserted in the same cycle as the final mem_wr_en.
- State changes take effect on the tick following the count reaching its limit. No beat is lost across phase boundaries.
- Reset values:
  - state IDLE, bank 0
  - all counters 0
  - mem_wr_en 0, mem_wr_addr 0, mem_wr_data 0
  - cp_mrkr 0, bank_done 0, bank_done_id 0, frame_err 0
  - stat_* 0
- Reset mid-frame: immediate return to IDLE with no writes and no bank_done. The first frame after reset uses bank 0.
- With clk_en low, outputs hold except the pulse outputs (mem_wr_en, bank_done, frame_err), which deassert.

## Configuration
- JB_PRACH_WR_STATS_EN defined: stat_frames counts bank_done pulses and stat_errs counts frame_err pulses. Both are 16-bit saturating and reset to 0.
- Not defined: both ports are tied to 0 and no counter logic is generated.

## Structure
- Shared package jb_prach_pkg holds:
  - the state enum (IDLE, OFFSET, CP, DATA)
  - a typedef for the packed write address {bank, ant, sym, idx}
  - a function computing address width from USR_ID_BW, SYM_BW, FFT_LOG2
- Sub-module jb_prach_wr_addr_gen owns the idx/sym counters and the address packing. The top keeps the FSM, phase counters, bank toggling and statistics.

## Test plan
All scenarios use NUM_ANT=2, FFT_LOG2=4, SYM_BW=1.
- Reset: assert reset mid-stream → all outputs 0 and state IDLE. The next frame writes bank 0.
- Basic frame: offset=3, cp=5, num_sym=2, continuous beats from the marker cycle → exactly 64 writes.
  - First write occurs at tick 8, ant 0: addr 0.
  - Last write addr = {0,1,1,15}, with bank_done=1 and id=0 in the same cycle.
  - cp_mrkr is high for 10 beats.
- Back-to-back frames: second frame writes have bit 7 = 1, bank_done_id=1. A third frame returns to bank 0.
- Zero lengths: offset=0, cp=0, num_sym=0 → the write at the marker beat is addr 0, with 32 writes total.
- Abort: marker during DATA sym 0, idx 6 → frame_err pulse, restart on bank 0, and no bank_done until the new frame completes. With the macro defined, stat_errs=1.
- Stall: tvalid gaps and clk_en low inside CP and DATA → identical address/data sequence to the basic frame, with no extra or missing writes.

Source files
------------

// File: rtl/jb_prach_pkg.sv
// jb_prach_pkg: FSM states, write-address layout and address-width helper
// shared by the PRACH CP-strip write path.
package jb_prach_pkg;
    typedef enum logic [1:0] {IDLE, OFFSET, CP, DATA} prach_state_e;
    localparam int DEF_USR_ID_BW = 2;
    localparam int DEF_SYM_BW = 2;
    localparam int DEF_FFT_LOG2 = 11;
    // layout of the RAM address at the default widths; MSB selects the ping-pong bank
    typedef struct packed {
        logic bank;
        logic [DEF_USR_ID_BW-1:0] ant;
        logic [DEF_SYM_BW-1:0] sym;
        logic [DEF_FFT_LOG2-1:0] idx;
    } wr_addr_t;
    function automatic int wr_addr_w(input int usr_id_bw, input int sym_bw, input int fft_log2);
        return 1 + usr_id_bw + sym_bw + fft_log2;
    endfunction
endpackage

// File: rtl/jb_axi4_stream_if.sv
// jb_axi4_stream_if: minimal AXI4-Stream beat bus (tvalid/tready/tdata/tuser).
interface jb_axi4_stream_if #(
    parameter int DATA_W = 32,
    parameter int USER_W = 2
);
    logic tvalid;
    logic tready;
    logic [DATA_W-1:0] tdata;
    logic [USER_W-1:0] tuser;
    modport master(output tvalid, tdata, tuser, input tready);
    modport slave(input tvalid, tdata, tuser, output tready);
endinterface

// File: rtl/jb_prach_wr_addr_gen.sv
// jb_prach_wr_addr_gen: idx/sym window counters and {bank, ant, sym, idx} address packing.
module jb_prach_wr_addr_gen
    import jb_prach_pkg::*;
#(
    parameter int USR_ID_BW = 2,
    parameter int SYM_BW = 2,
    parameter int FFT_LOG2 = 11
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic adv,
    input  logic bank,
    input  logic [USR_ID_BW-1:0] ant,
    input  logic [SYM_BW:0] num_sym,
    output logic [wr_addr_w(USR_ID_BW, SYM_BW, FFT_LOG2)-1:0] addr,
    output logic last
);
    logic [FFT_LOG2-1:0] idx_q, idx_c;
    logic [SYM_BW-1:0] sym_q, sym_c;

    // a marker restarts the window so the marker beat itself lands on idx 0
    assign idx_c = clr ? '0 : idx_q;
    assign sym_c = clr ? '0 : sym_q;
    assign last = &idx_c && ({1'b0, sym_c} + (SYM_BW+1)'(1) == num_sym);
    assign addr = {bank, ant, sym_c, idx_c};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q <= '0;
            sym_q <= '0;
        end else if (adv) begin
            idx_q <= idx_c + FFT_LOG2'(1);
            sym_q <= sym_c + SYM_BW'(&idx_c);
        end else if (clr) begin
            idx_q <= '0;
            sym_q <= '0;
        end
    end
endmodule

// File: rtl/jb_prach_cp_strip_wr.sv
// jb_prach_cp_strip_wr: PRACH offset/CP removal and ping-pong FFT-buffer writer.
// Optional saturating frame/error statistics under JB_PRACH_WR_STATS_EN.
module jb_prach_cp_strip_wr
    import jb_prach_pkg::*;
#(
    parameter int USR_ID_BW = 2,
    parameter int NUM_ANT = 4,
    parameter int PRECISION = 16,
    parameter int FFT_LOG2 = 11,
    parameter int SYM_BW = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_en,
    input  logic sub_frame_mrkr,
    input  logic [15:0] cfg_offset,
    input  logic [15:0] cfg_cp_len,
    input  logic [SYM_BW:0] cfg_num_sym,
    jb_axi4_stream_if.slave IFP_in,
    output logic mem_wr_en,
    output logic [wr_addr_w(USR_ID_BW, SYM_BW, FFT_LOG2)-1:0] mem_wr_addr,
    output logic [2*PRECISION-1:0] mem_wr_data,
    output logic cp_mrkr,
    output logic bank_done,
    output logic bank_done_id,
    output logic frame_err,
    output logic [15:0] stat_frames,
    output logic [15:0] stat_errs
);
    localparam int AW = wr_addr_w(USR_ID_BW, SYM_BW, FFT_LOG2);
    localparam logic [USR_ID_BW-1:0] ANT_LAST = USR_ID_BW'(NUM_ANT - 1);

    prach_state_e state_q, state_d, st_e;
    logic [15:0] cnt_q, cnt_d, cnt_e, off_q, cp_q, off_e, cp_e, lim;
    logic [SYM_BW:0] nsym_q, nsym_e;
    logic bank_q, mrk, beat, tick, wr, adv, done, err, last, at_lim;
    logic [AW-1:0] addr;

    assign IFP_in.tready = 1'b1;
    assign mrk = clk_en && sub_frame_mrkr;
    assign beat = clk_en && IFP_in.tvalid;
    assign tick = beat && IFP_in.tuser == ANT_LAST;
    // the marker cycle already runs on the new frame's config and phase
    assign off_e = mrk ? cfg_offset : off_q;
    assign cp_e = mrk ? cfg_cp_len : cp_q;
    assign nsym_e = !mrk ? nsym_q : cfg_num_sym == '0 ? (SYM_BW+1)'(1) : cfg_num_sym;
    assign cnt_e = mrk ? '0 : cnt_q;
    assign st_e = !mrk ? state_q : cfg_offset != '0 ? OFFSET : cfg_cp_len != '0 ? CP : DATA;
    assign lim = st_e == OFFSET ? off_e : cp_e;
    assign at_lim = cnt_e == lim - 16'd1;
    assign wr = beat && st_e == DATA && int'(IFP_in.tuser) < NUM_ANT;
    assign adv = tick && st_e == DATA;
    assign done = adv && last;
    assign err = mrk && state_q != IDLE;

    jb_prach_wr_addr_gen #(
        .USR_ID_BW(USR_ID_BW),
        .SYM_BW(SYM_BW),
        .FFT_LOG2(FFT_LOG2)
    ) u_addr_gen (
        .clk(clk),
        .reset(reset),
        .clr(mrk),
        .adv(adv),
        .bank(bank_q),
        .ant(IFP_in.tuser),
        .num_sym(nsym_e),
        .addr(addr),
        .last(last)
    );

    always_comb begin
        state_d = st_e;
        cnt_d = cnt_e;
        if (tick && (st_e == OFFSET || st_e == CP)) begin
            cnt_d = at_lim ? '0 : cnt_e + 16'd1;
            state_d = !at_lim ? st_e : (st_e == OFFSET && cp_e != '0) ? CP : DATA;
        end
        if (done) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            off_q <= '0;
            cp_q <= '0;
            nsym_q <= '0;
            bank_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            off_q <= off_e;
            cp_q <= cp_e;
            nsym_q <= nsym_e;
            bank_q <= bank_q ^ done;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_wr_en <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            cp_mrkr <= 1'b0;
            bank_done <= 1'b0;
            bank_done_id <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            mem_wr_en <= wr;
            bank_done <= done;
            frame_err <= err;
            if (wr) mem_wr_addr <= addr;
            if (wr) mem_wr_data <= IFP_in.tdata;
            if (clk_en) cp_mrkr <= beat && st_e == CP;
            if (done) bank_done_id <= bank_q;
        end
    end

`ifdef JB_PRACH_WR_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_frames <= '0;
            stat_errs <= '0;
        end else begin
            if (done && ~&stat_frames) stat_frames <= stat_frames + 16'd1;
            if (err && ~&stat_errs) stat_errs <= stat_errs + 16'd1;
        end
    end
`else
    assign stat_frames = '0;
    assign stat_errs = '0;
`endif
endmodule

// File: tb/tb_jb_prach_cp_strip_wr.sv
// tb_jb_prach_cp_strip_wr: sample-position reference model plus directed and random frames.
module tb_jb_prach_cp_strip_wr;
    localparam int UB = 2;
    localparam int NA = 2;
    localparam int PR = 16;
    localparam int FL = 4;
    localparam int SB = 1;
    localparam int AW = 1 + UB + SB + FL;
    localparam int DW = 2 * PR;
    localparam int WIN = 1 << FL;

    logic clk = 0, reset = 1, clk_en = 0, sub_frame_mrkr = 0;
    logic [15:0] cfg_offset = 0, cfg_cp_len = 0;
    logic [SB:0] cfg_num_sym = 0;
    logic mem_wr_en, cp_mrkr, bank_done, bank_done_id, frame_err;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;
    logic [15:0] stat_frames, stat_errs;

    jb_axi4_stream_if #(.DATA_W(DW), .USER_W(UB)) ifp();

    jb_prach_cp_strip_wr #(
        .USR_ID_BW(UB), .NUM_ANT(NA), .PRECISION(PR), .FFT_LOG2(FL), .SYM_BW(SB)
    ) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .sub_frame_mrkr(sub_frame_mrkr),
        .cfg_offset(cfg_offset), .cfg_cp_len(cfg_cp_len), .cfg_num_sym(cfg_num_sym),
        .IFP_in(ifp), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .cp_mrkr(cp_mrkr), .bank_done(bank_done),
        .bank_done_id(bank_done_id), .frame_err(frame_err),
        .stat_frames(stat_frames), .stat_errs(stat_errs)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: frame position is counted in samples since the marker
    bit m_act = 0, m_bank = 0;
    int m_s = 0, m_off = 0, m_cp = 0, m_nsym = 1, w;
    logic e_wr = 0, e_cp = 0, e_done = 0, e_id = 0, e_err = 0;
    logic [AW-1:0] e_addr = 0;
    logic [DW-1:0] e_data = 0;
    int e_sf = 0, e_se = 0;

    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_act = 0; m_bank = 0; m_s = 0;
            e_wr = 0; e_cp = 0; e_done = 0; e_id = 0; e_err = 0;
            e_addr = 0; e_data = 0; e_sf = 0; e_se = 0;
        end else begin
            e_wr = 0; e_done = 0; e_err = 0;
            if (clk_en) begin
                if (sub_frame_mrkr) begin
                    e_err = m_act;
                    m_act = 1; m_s = 0;
                    m_off = int'(cfg_offset); m_cp = int'(cfg_cp_len);
                    m_nsym = cfg_num_sym == 0 ? 1 : int'(cfg_num_sym);
                end
                e_cp = ifp.tvalid && m_act && m_s >= m_off && m_s < m_off + m_cp;
                if (ifp.tvalid && m_act && m_s >= m_off + m_cp) begin
                    w = m_s - m_off - m_cp;
                    if (int'(ifp.tuser) < NA) begin
                        e_wr = 1;
                        e_addr = AW'(int'(m_bank) * (1 << (AW - 1)) + int'(ifp.tuser) * (1 << (SB + FL)) + w);
                        e_data = ifp.tdata;
                    end
                    if (int'(ifp.tuser) == NA - 1 && w == m_nsym * WIN - 1) begin
                        e_done = 1; e_id = m_bank; m_bank = !m_bank; m_act = 0;
                    end
                end
                if (ifp.tvalid && m_act && int'(ifp.tuser) == NA - 1) m_s++;
`ifdef JB_PRACH_WR_STATS_EN
                if (e_done && e_sf < 65535) e_sf++;
                if (e_err && e_se < 65535) e_se++;
`endif
            end
        end
    end

    logic [AW-1:0] wa[$], ba[$];
    logic [DW-1:0] wd[$], bd[$];
    int n_done = 0, n_err = 0, n_cp = 0;
    logic done_id = 0, done_wr = 0;
    logic [AW-1:0] done_addr = 0;

    initial forever begin
        @(negedge clk);
        chk("wr_en", 32'(mem_wr_en), 32'(e_wr));
        chk("wr_addr", 32'(mem_wr_addr), 32'(e_addr));
        chk("wr_data", mem_wr_data, e_data);
        chk("cp_mrkr", 32'(cp_mrkr), 32'(e_cp));
        chk("bank_done", 32'(bank_done), 32'(e_done));
        chk("bank_done_id", 32'(bank_done_id), 32'(e_id));
        chk("frame_err", 32'(frame_err), 32'(e_err));
        chk("stat_frames", 32'(stat_frames), 32'(e_sf));
        chk("stat_errs", 32'(stat_errs), 32'(e_se));
        if (mem_wr_en) begin wa.push_back(mem_wr_addr); wd.push_back(mem_wr_data); end
        if (bank_done) begin n_done++; done_id = bank_done_id; done_wr = mem_wr_en; done_addr = mem_wr_addr; end
        if (frame_err) n_err++;
        if (cp_mrkr) n_cp++;
    end

    function automatic logic [DW-1:0] bdata(input int k);
        return 32'h5A5A0000 ^ (32'(k) * 32'h00010003);
    endfunction

    task automatic drive(input logic m, input logic ce, input logic v, input logic [UB-1:0] u, input logic [DW-1:0] d);
        sub_frame_mrkr = m; clk_en = ce; ifp.tvalid = v; ifp.tuser = u; ifp.tdata = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 1, 0, '0, '0);
    endtask

    task automatic clr_log();
        wa.delete(); wd.delete(); n_done = 0; n_err = 0; n_cp = 0; done_wr = 0; done_addr = 0;
    endtask

    task automatic do_reset();
        #1;
        reset = 1; clk_en = 0; ifp.tvalid = 0; sub_frame_mrkr = 0;
        @(negedge clk);
        chk("rst_wr_en", 32'(mem_wr_en), 0);
        chk("rst_addr", 32'(mem_wr_addr), 0);
        chk("rst_data", mem_wr_data, 0);
        chk("rst_cp", 32'(cp_mrkr), 0);
        chk("rst_done", 32'(bank_done | bank_done_id | frame_err), 0);
        repeat (2) @(negedge clk);
        reset = 0;
        idle(2);
        clr_log();
    endtask

    // beat k carries ant k%NA; marker on beat 0; optional gaps and clock-enable drops
    task automatic run_frame(input int off, input int cp, input int ns, input bit stall, input int nbeats);
        int k = 0;
        cfg_offset = 16'(off); cfg_cp_len = 16'(cp); cfg_num_sym = (SB+1)'(ns);
        while (k < nbeats) begin
            if (stall && k > 0 && $urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 1) drive(1, 0, 1, UB'(k % NA), '1);
                else drive(0, 1, 0, UB'(k % NA), '1);
            end else begin
                drive(k == 0, 1, 1, UB'(k % NA), bdata(k));
                k++;
            end
        end
    endtask

    function automatic int bank_cnt(input bit b);
        int c = 0;
        foreach (wa[i]) if (wa[i][AW-1] == b) c++;
        return c;
    endfunction

    initial begin
        int diff;
        ifp.tvalid = 0; ifp.tuser = 0; ifp.tdata = 0;
        repeat (3) @(negedge clk);
        chk("init_wr_en", 32'(mem_wr_en), 0);
        chk("init_addr", 32'(mem_wr_addr), 0);
        chk("init_stats", 32'({stat_frames, stat_errs}), 0);
        reset = 0;
        idle(2);
        clr_log();

        run_frame(3, 5, 2, 0, 80); idle(3);
        chk("basic_nwr", wa.size(), 64);
        chk("basic_first_addr", 32'(wa[0]), 0);
        chk("basic_first_data", wd[0], bdata(16));
        chk("basic_last_addr", 32'(wa[$]), 32'h3F);
        chk("basic_ndone", n_done, 1);
        chk("basic_done_id", 32'(done_id), 0);
        chk("basic_done_wr", 32'(done_wr), 1);
        chk("basic_done_addr", 32'(done_addr), 32'h3F);
        chk("basic_cp_beats", n_cp, 10);
        ba = wa; bd = wd;
        clr_log();

        run_frame(3, 5, 2, 0, 80); idle(3);
        chk("b2b_bank1_wr", bank_cnt(1), 64);
        chk("b2b_done_id", 32'(done_id), 1);
        clr_log();
        run_frame(3, 5, 2, 0, 80); idle(3);
        chk("b2b_bank0_wr", bank_cnt(0), 64);
        chk("b2b_done_id3", 32'(done_id), 0);

        run_frame(3, 5, 2, 0, 40);
        do_reset();
        run_frame(0, 0, 0, 0, 36); idle(3);
        chk("zero_first_addr", 32'(wa[0]), 0);
        chk("zero_first_data", wd[0], bdata(0));
        chk("zero_nwr", wa.size(), 32);
        chk("zero_done_id", 32'(done_id), 0);

        do_reset();
        run_frame(3, 5, 2, 0, 28);
        chk("abort_pre_done", n_done, 0);
        run_frame(3, 5, 2, 0, 80); idle(3);
        chk("abort_nerr", n_err, 1);
        chk("abort_ndone", n_done, 1);
        chk("abort_done_id", 32'(done_id), 0);
        chk("abort_nwr", wa.size(), 76);
        chk("abort_bank0", bank_cnt(0), 76);
        chk("abort_done_addr", 32'(done_addr), 32'h3F);
`ifdef JB_PRACH_WR_STATS_EN
        chk("abort_stat_errs", 32'(stat_errs), 1);
`else
        chk("abort_stat_errs", 32'(stat_errs), 0);
`endif
        clr_log();

        run_frame(3, 5, 2, 1, 80); idle(3);
        chk("stall_nwr", wa.size(), 64);
        chk("stall_ndone", n_done, 1);
        diff = 0;
        for (int i = 0; i < 64 && i < wa.size(); i++)
            if (wa[i][AW-2:0] !== ba[i][AW-2:0] || wd[i] !== bd[i]) diff++;
        chk("stall_seq_diff", diff, 0);

        for (int c = 0; c < 4000; c++) begin
            cfg_offset = 16'($urandom_range(0, 4));
            cfg_cp_len = 16'($urandom_range(0, 4));
            cfg_num_sym = (SB+1)'($urandom_range(0, 2));
            drive($urandom_range(0, 149) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) == 0 ? UB'($urandom_range(NA, (1 << UB) - 1)) : UB'($urandom_range(0, NA - 1)),
                  DW'($urandom));
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
